uart_rx: RTL

// - UART receiver; consumes the 16x-oversampling baud tick from the baud-rate timer (its done output).
// - Detects the start bit, samples each data bit at mid-bit, and checks the stop bit.
// - Delivers each received byte with a one-cycle valid strobe and a framing-error flag.
// - Sits between the async rx pin and the receive FIFO or user logic. Its counterpart is uart_tx.
//

---
 rtl/uart_rx_if.sv | 22 ++
 rtl/uart_rx.sv | 117 +++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle for uart_rx: oversample tick and serial line in,
// received word and status out.
interface uart_rx_if #(
    parameter int DBIT = 8
);
    logic            s_tick;
    logic            rx;
    logic [DBIT-1:0] rx_dout;
    logic            rx_done_tick;
    logic            framing_err;
    logic            busy;

    modport master (
        output s_tick, rx,
        input  rx_dout, rx_done_tick, framing_err, busy
    );

    modport slave (
        input  s_tick, rx,
        output rx_dout, rx_done_tick, framing_err, busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver driven by a 16x oversample tick: start-bit qualification,
// mid-bit data sampling, stop-bit check, one-clk done strobe with framing error.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    uart_rx_if.slave    bus
);
    localparam int              NW     = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [4:0]      SB_LAST = 5'(SB_TICK - 1);
    localparam logic [NW-1:0]   N_LAST  = NW'(DBIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             r_state;
    logic [4:0]         r_s_cnt;
    logic [NW-1:0]      r_n_cnt;
    logic [DBIT-1:0]    r_b;
    logic               r_sync1;
    logic               r_sync2;
    logic [DBIT-1:0]    r_dout;
    logic               r_done;
    logic               r_ferr;
    logic               r_busy;
    logic               r_armed;
    logic               w_rx_s;

    assign w_rx_s           = r_sync2;
    assign bus.rx_dout      = r_dout;
    assign bus.rx_done_tick = r_done;
    assign bus.framing_err  = r_ferr;
    assign bus.busy         = r_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_s_cnt <= '0;
            r_n_cnt <= '0;
            r_b     <= '0;
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
            r_armed <= 1'b1;
        end else begin
            r_sync1 <= bus.rx;
            r_sync2 <= r_sync1;
            r_done  <= 1'b0;
            // A break disarms the receiver until the line has been seen high again
            if (w_rx_s)
                r_armed <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= START;
                        r_s_cnt <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (bus.s_tick) begin
                        if (r_s_cnt == 5'd7) begin
                            if (!w_rx_s && r_armed) begin
                                r_state <= DATA;
                                r_s_cnt <= '0;
                                r_n_cnt <= '0;
                            end else begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_s_cnt <= r_s_cnt + 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (bus.s_tick) begin
                        if (r_s_cnt == 5'd15) begin
                            r_s_cnt <= '0;
                            r_b     <= {w_rx_s, r_b[DBIT-1:1]};
                            if (r_n_cnt == N_LAST)
                                r_state <= STOP;
                            else
                                r_n_cnt <= r_n_cnt + NW'(1);
                        end else begin
                            r_s_cnt <= r_s_cnt + 5'd1;
                        end
                    end
                end
                STOP: begin
                    if (bus.s_tick) begin
                        if (r_s_cnt == SB_LAST) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_dout  <= r_b;
                            r_ferr  <= ~w_rx_s;
                            r_done  <= 1'b1;
                            if (!w_rx_s && (r_b == '0))
                                r_armed <= 1'b0;
                        end else begin
                            r_s_cnt <= r_s_cnt + 5'd1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
